// File: rtl/layer_stage_seq.sv
// Per-layer sequencer: runs the seven sub-engine stages of one transformer layer
// over start/done pulse handshakes, tracks the layer index and flags protocol errors/stalls.
module layer_stage_seq #(
  parameter int NUM_LAYER   = 12,
  parameter int LAYER_W     = 4,
  parameter int TIMEOUT_CYC = 4096,
  parameter int TO_W        = 13
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ln_start,
  input  logic [6:0]         stage_done,
  output logic [6:0]         stage_start,
  output logic               linear2_done,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               busy,
  output logic               err_proto,
  output logic               err_timeout
);

  // state | meaning
  // IDLE  | waiting for ln_start
  // ISSUE | stage_start[stage] high for this single cycle
  // WAIT  | waiting for stage_done[stage], watchdog running
  // FIN   | linear2_done high; a new ln_start is accepted here
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIN} state_t;

  localparam logic [TO_W-1:0]    WD_LAST    = (TIMEOUT_CYC == 0) ? '0 : TO_W'(TIMEOUT_CYC - 1);
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYER - 1);
  localparam logic [2:0]         LAST_STAGE = 3'd6;

  state_t             state, state_nxt;
  logic [2:0]         stage, stage_nxt;
  logic [TO_W-1:0]    wd, wd_nxt;
  logic [LAYER_W-1:0] idx_nxt;
  logic               proto_nxt, to_nxt;
  logic [6:0]         start_nxt;
  logic               l2d_nxt, busy_nxt;
  logic [6:0]         exp_mask;
  logic               done_ok, stray, wd_expire;

  always_comb begin
    exp_mask  = (state == S_WAIT) ? (7'b1 << stage) : 7'b0;
    done_ok   = |(stage_done & exp_mask);
    stray     = |(stage_done & ~exp_mask);
    wd_expire = (TIMEOUT_CYC != 0) && (wd == WD_LAST);

    state_nxt = state;
    stage_nxt = stage;
    wd_nxt    = wd;
    idx_nxt   = layer_idx;
    proto_nxt = err_proto | stray;
    to_nxt    = err_timeout;

    case (state)
      S_IDLE: begin
        if (ln_start) begin
          state_nxt = S_ISSUE;
          stage_nxt = 3'd0;
        end
      end
      S_ISSUE: begin
        state_nxt = S_WAIT;
        wd_nxt    = '0;
        if (ln_start) proto_nxt = 1'b1;
      end
      S_WAIT: begin
        if (ln_start) proto_nxt = 1'b1;
        // a done on the expiry cycle takes priority over the timeout
        if (done_ok) begin
          if (stage == LAST_STAGE) begin
            state_nxt = S_FIN;
            idx_nxt   = (layer_idx == LAST_LAYER) ? '0 : layer_idx + 1'b1;
          end else begin
            state_nxt = S_ISSUE;
            stage_nxt = stage + 3'd1;
          end
        end else if (wd_expire) begin
          state_nxt = S_IDLE;
          to_nxt    = 1'b1;
        end else begin
          wd_nxt = wd + 1'b1;
        end
      end
      S_FIN: begin
        if (ln_start) begin
          state_nxt = S_ISSUE;
          stage_nxt = 3'd0;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // outputs are registered copies of what the next state implies
    start_nxt = (state_nxt == S_ISSUE) ? (7'b1 << stage_nxt) : 7'b0;
    l2d_nxt   = (state_nxt == S_FIN);
    busy_nxt  = (state_nxt == S_ISSUE) || (state_nxt == S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      stage        <= 3'd0;
      wd           <= '0;
      layer_idx    <= '0;
      err_proto    <= 1'b0;
      err_timeout  <= 1'b0;
      stage_start  <= 7'b0;
      linear2_done <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      stage        <= stage_nxt;
      wd           <= wd_nxt;
      layer_idx    <= idx_nxt;
      err_proto    <= proto_nxt;
      err_timeout  <= to_nxt;
      stage_start  <= start_nxt;
      linear2_done <= l2d_nxt;
      busy         <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_layer_stage_seq.sv
// Scoreboard bench for layer_stage_seq: expected stage starts and layer indices are
// queued when a layer is launched and compared as the DUT emits them.
module tb_layer_stage_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       ln_start;
  logic [6:0] stage_done;
  logic [6:0] stage_start;
  logic       linear2_done;
  logic [3:0] layer_idx;
  logic       busy;
  logic       err_proto;
  logic       err_timeout;

  layer_stage_seq #(
    .NUM_LAYER(12), .LAYER_W(4), .TIMEOUT_CYC(8), .TO_W(4)
  ) dut (
    .clk(clk), .reset(reset), .ln_start(ln_start), .stage_done(stage_done),
    .stage_start(stage_start), .linear2_done(linear2_done), .layer_idx(layer_idx),
    .busy(busy), .err_proto(err_proto), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_chk  = 0;
  int         n_pass = 0;
  logic [6:0] exp_start_q[$];
  logic [3:0] exp_idx_q[$];
  logic [3:0] mdl_idx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (stage_start != 7'b0) begin
        if (exp_start_q.size() == 0) chk("start_extra", 32'(stage_start), 32'd0);
        else chk("stage_start", 32'(stage_start), 32'(exp_start_q.pop_front()));
      end
      if (linear2_done) begin
        if (exp_idx_q.size() == 0) chk("l2d_extra", 32'(linear2_done), 32'd0);
        else chk("layer_idx", 32'(layer_idx), 32'(exp_idx_q.pop_front()));
        chk("busy_at_l2d", 32'(busy), 32'd0);
      end
    end
  end

  // mode 0 normal, 1 stray done + ln_start at stage ms, 2 withhold done at stage ms,
  // 3 reset in the WAIT of stage ms. Called and returns at a falling edge.
  task automatic do_layer(input int dly, input int mode, input int ms);
    int  t0, w, n_push;
    bit  timed;
    timed  = (mode == 0);
    n_push = (mode >= 2) ? ms + 1 : 7;
    for (int k = 0; k < n_push; k++) exp_start_q.push_back(7'(1 << k));
    if (mode < 2) begin
      mdl_idx = (mdl_idx == 4'd11) ? 4'd0 : mdl_idx + 4'd1;
      exp_idx_q.push_back(mdl_idx);
    end
    ln_start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    ln_start = 1'b0;
    chk("busy_on", 32'(busy), 32'd1);
    for (int k = 0; k < 7; k++) begin
      w = 0;
      while (!stage_start[k] && w < 40) begin @(negedge clk); w++; end
      if (!stage_start[k]) begin
        chk("start_wait", 32'(stage_start), 32'(7'(1 << k)));
        return;
      end
      if (timed) chk("start_time", 32'(cyc - t0), 32'(1 + k * (dly + 1)));
      if (mode == 1 && k == ms) begin
        @(negedge clk);
        stage_done = 7'b0010000;
        @(negedge clk);
        stage_done = 7'b0;
        ln_start   = 1'b1;
        chk("err_proto_set", 32'(err_proto), 32'd1);
        @(negedge clk);
        ln_start = 1'b0;
        chk("stage_hold", 32'(stage_start), 32'd0);
        stage_done[k] = 1'b1;
        @(negedge clk);
        stage_done = 7'b0;
      end else if (mode == 2 && k == ms) begin
        repeat (8) @(negedge clk);
        chk("to_early", 32'(err_timeout), 32'd0);
        chk("busy_pre_to", 32'(busy), 32'd1);
        @(negedge clk);
        chk("err_timeout", 32'(err_timeout), 32'd1);
        chk("busy_after_to", 32'(busy), 32'd0);
        chk("idx_hold", 32'(layer_idx), 32'(mdl_idx));
        return;
      end else if (mode == 3 && k == ms) begin
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_start", 32'(stage_start), 32'd0);
        chk("rst_l2d", 32'(linear2_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_idx", 32'(layer_idx), 32'd0);
        chk("rst_proto", 32'(err_proto), 32'd0);
        chk("rst_to", 32'(err_timeout), 32'd0);
        reset   = 1'b0;
        mdl_idx = 4'd0;
        return;
      end else begin
        repeat (dly) @(negedge clk);
        stage_done[k] = 1'b1;
        @(negedge clk);
        stage_done = 7'b0;
      end
    end
    w = 0;
    while (!linear2_done && w < 40) begin @(negedge clk); w++; end
    chk("l2d_seen", 32'(linear2_done), 32'd1);
    if (timed) chk("latency", 32'(cyc - t0), 32'(7 * (dly + 1) + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    reset      = 1'b1;
    ln_start   = 1'b0;
    stage_done = 7'b0;
    mdl_idx    = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_state", {stage_start, linear2_done, layer_idx, busy, err_proto, err_timeout}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // done two cycles after each start
    do_layer(2, 0, 0);
    @(negedge clk);
    chk("busy_low", 32'(busy), 32'd0);
    chk("idx_after_1", 32'(layer_idx), 32'd1);

    // eleven more layers, minimum latency, ln_start in each FIN cycle
    for (int i = 0; i < 11; i++) do_layer(1, 0, 0);
    @(negedge clk);
    chk("idx_wrap", 32'(layer_idx), 32'd0);
    chk("no_proto", 32'(err_proto), 32'd0);
    chk("no_to", 32'(err_timeout), 32'd0);

    do_layer(1, 1, 2);
    @(negedge clk);
    chk("proto_sticky", 32'(err_proto), 32'd1);
    chk("idx_after_proto", 32'(layer_idx), 32'd1);

    do_layer(1, 2, 3);
    @(negedge clk);
    do_layer(1, 0, 0);
    @(negedge clk);
    chk("to_sticky", 32'(err_timeout), 32'd1);
    chk("idx_after_recover", 32'(layer_idx), 32'd2);

    do_layer(1, 3, 5);
    @(negedge clk);
    chk("start_q_empty", 32'(exp_start_q.size()), 32'd0);
    do_layer(1, 0, 0);
    @(negedge clk);
    chk("idx_after_reset", 32'(layer_idx), 32'd1);
    chk("idx_q_empty", 32'(exp_idx_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
